// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a registered borrow,
// LSB-first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  sa_q, sb_q, res_q, diff_q;
    logic              borrow_q, bout_q, ovalid_q;
    logic [CW-1:0]     cnt_q;

    logic              a0, b0, d_bit, borrow_d;
    logic [WIDTH-1:0]  res_d;

    always_comb begin
        a0       = sa_q[0];
        b0       = sb_q[0];
        d_bit    = a0 ^ b0 ^ borrow_q;
        borrow_d = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
        res_d    = {d_bit, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    // The last bit lands in diff on the same edge it is produced.
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        bout_q   <= borrow_d;
                        ovalid_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        ovalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = ovalid_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
endmodule
